// File: rtl/shexscan_if.sv
// shexscan_if: frame-load and decoder/digit-drive signals of the shexscan
// multiplexed-display scan controller. The master side supplies frame data;
// the slave side (shexscan) drives the decoder and digit-select lines.
interface shexscan_if #(
  parameter int NDIGITS = 4
);
  logic                   load;
  logic [4*NDIGITS-1:0]   data;
  logic [NDIGITS-1:0]     dots;
  logic [NDIGITS-1:0]     digit_en;
  logic [3:0]             value;
  logic [1:0]             enable;
  logic                   dot;
  logic [NDIGITS-1:0]     digit_sel;
  logic                   frame_tick;

  modport master (
    output load, data, dots, digit_en,
    input  value, enable, dot, digit_sel, frame_tick
  );

  modport slave (
    input  load, data, dots, digit_en,
    output value, enable, dot, digit_sel, frame_tick
  );
endinterface

// File: rtl/shexscan.sv
// shexscan: multiplexed hex display scan controller.
// Holds a double-buffered frame (nibbles, dots, enables), scans one digit per
// PRESCALE-cycle slot with a BLANK_CYCLES anti-ghosting gap at slot start.
// Optional leading-zero blanking is enabled by defining SHEXSCAN_LZB_EN.
module shexscan #(
  parameter int NDIGITS      = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic  clk,
  input  logic  reset,
  shexscan_if.slave bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = ($clog2(NDIGITS) < 1) ? 1 : $clog2(NDIGITS);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  // Scan position
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  // Active (displayed) and shadow (pending) frame buffers
  logic [4*NDIGITS-1:0]   act_data, sh_data;
  logic [NDIGITS-1:0]     act_dots, sh_dots;
  logic [NDIGITS-1:0]     act_en, sh_en;
  logic                   pending;

  // Registered outputs
  logic [3:0]             value_q;
  logic [1:0]             enable_q;
  logic                   dot_q;
  logic [NDIGITS-1:0]     sel_q;
  logic                   tick_q;

  // Next-cycle view used to build registered outputs
  logic                   last_cnt, last_idx, frame_start, swap;
  logic [CW-1:0]          nxt_cnt;
  logic [IW-1:0]          nxt_idx;
  logic [4*NDIGITS-1:0]   nxt_data;
  logic [NDIGITS-1:0]     nxt_dots, nxt_en, nxt_sup;
  phase_t                 nxt_phase;
  logic [3:0]             cur_val;
  logic                   cur_dot, cur_en, cur_sup;

  assign bus.value      = value_q;
  assign bus.enable     = enable_q;
  assign bus.dot        = dot_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;

  // Advance the scan position and decide whether this edge starts a frame
  always_comb begin
    last_cnt    = (cnt == CW'(PRESCALE - 1));
    last_idx    = (idx == IW'(NDIGITS - 1));
    frame_start = last_cnt && last_idx;
    swap        = frame_start && pending;
    nxt_cnt     = last_cnt ? '0 : cnt + 1'b1;
    nxt_idx     = idx;
    if (last_cnt) begin
      nxt_idx = last_idx ? '0 : idx + 1'b1;
    end
    nxt_data    = swap ? sh_data : act_data;
    nxt_dots    = swap ? sh_dots : act_dots;
    nxt_en      = swap ? sh_en   : act_en;
    nxt_phase   = (nxt_cnt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
  end

  // Leading-zero suppression mask over the buffer that will be displayed
  always_comb begin
    nxt_sup = '0;
`ifdef SHEXSCAN_LZB_EN
    begin
      logic chain;
      chain = 1'b1;
      for (int unsigned i = NDIGITS - 1; i >= 1; i--) begin
        if (chain && (nxt_data[4*i +: 4] == 4'h0) && !nxt_dots[i]) begin
          nxt_sup[i] = 1'b1;
        end else begin
          chain = 1'b0;
        end
      end
    end
`endif
  end

  // Select the nibble, dot and enable of the digit at the next position
  always_comb begin
    cur_val = '0;
    cur_dot = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (nxt_idx == IW'(i)) begin
        cur_val = nxt_data[4*i +: 4];
        cur_dot = nxt_dots[i];
        cur_en  = nxt_en[i];
        cur_sup = nxt_sup[i];
      end
    end
  end

  // Scan counters, double buffer and registered display outputs.
  // Outputs are computed from the next position/buffer so that they line up
  // with the scan position held in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      act_data <= '0;
      act_dots <= '0;
      act_en   <= '0;
      sh_data  <= '0;
      sh_dots  <= '0;
      sh_en    <= '0;
      pending  <= 1'b0;
      value_q  <= '0;
      enable_q <= '0;
      dot_q    <= 1'b0;
      sel_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt <= nxt_cnt;
      idx <= nxt_idx;
      if (swap) begin
        act_data <= sh_data;
        act_dots <= sh_dots;
        act_en   <= sh_en;
      end
      // A load coinciding with a swap refills the shadow and keeps pending set
      if (bus.load) begin
        sh_data <= bus.data;
        sh_dots <= bus.dots;
        sh_en   <= bus.digit_en;
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
      tick_q <= frame_start;
      if (nxt_phase == PH_BLANK) begin
        sel_q    <= '0;
        value_q  <= '0;
        enable_q <= '0;
        dot_q    <= 1'b0;
      end else begin
        sel_q    <= NDIGITS'(1) << nxt_idx;
        value_q  <= cur_val;
        enable_q <= {1'b1, cur_en & ~cur_sup};
        dot_q    <= cur_dot;
      end
    end
  end

endmodule
